// File: rtl/hamming_receiver.sv
// ----------------------------------------------------------------------------
// hamming_receiver
//
// Serial receiver and decoder for extended-Hamming (16,11) codewords.
// Bits arrive one per enabled cycle, lowest codeword index first. When the
// sixteenth bit lands the whole word is captured, and on the following edge
// it is decoded (SEC-DED): single-bit errors are corrected, double-bit errors
// are flagged, and per-kind saturating error counters are updated.
//
// Ports:
//   clk           in   1   system clock, rising-edge active
//   reset         in   1   synchronous active-high reset
//   datain        in   1   serial codeword bit
//   enable        in   1   datain is sampled only when high
//   dataout       out  11  decoded data word
//   valid         out  1   one-cycle pulse marking a new decode result
//   err_corrected out  1   single-bit error corrected in current result
//   err_double    out  1   uncorrectable double-bit error in current result
//   err_pos       out  4   codeword index of corrected bit, 0 otherwise
//   corr_cnt      out  8   saturating count of corrected frames
//   dbl_cnt       out  8   saturating count of double-error frames
// ----------------------------------------------------------------------------
module hamming_receiver (
    input  logic        clk,
    input  logic        reset,
    input  logic        datain,
    input  logic        enable,
    output logic [10:0] dataout,
    output logic        valid,
    output logic        err_corrected,
    output logic        err_double,
    output logic [3:0]  err_pos,
    output logic [7:0]  corr_cnt,
    output logic [7:0]  dbl_cnt
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t      state;
    logic [3:0]  bit_idx;
    logic [14:0] held;
    logic [15:0] capture;
    logic        pending;

    logic [3:0]  syndrome;
    logic        parity;
    logic [15:0] fixed;
    logic [10:0] dec_data;

    // Receive FSM. Bit 15 is never stored in the held register: it goes
    // straight into the capture word on the same edge, so the next frame can
    // start filling the held register on the very next enabled cycle.
    // Pending lasts exactly one cycle because decode always consumes it on
    // the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= 4'd0;
            held    <= 15'd0;
            capture <= 16'd0;
            pending <= 1'b0;
        end else begin
            pending <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        held    <= {14'd0, datain};
                        bit_idx <= 4'd1;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (enable) begin
                        if (bit_idx == 4'd15) begin
                            capture <= {datain, held};
                            pending <= 1'b1;
                            bit_idx <= 4'd0;
                            state   <= IDLE;
                        end else begin
                            held[bit_idx] <= datain;
                            bit_idx       <= bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_idx <= 4'd0;
                end
            endcase
        end
    end

    // Syndrome is the XOR of the indices of all set bits 1..15; overall
    // parity covers all 16 bits. Odd parity means a single error sitting at
    // the syndrome index (index 0 being the overall parity bit itself). With
    // even parity the word is passed through unmodified, which gives the
    // uncorrected data for the double-error case.
    always_comb begin
        syndrome = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (capture[i]) begin
                syndrome = syndrome ^ 4'(i);
            end
        end
        parity = ^capture;
        fixed  = capture;
        if (parity) begin
            fixed[syndrome] = ~capture[syndrome];
        end
        dec_data = {fixed[15:9], fixed[7:5], fixed[3]};
    end

    // Decode stage: registers the result one edge after capture and emits
    // the valid pulse alongside it. Result fields hold until the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout       <= 11'd0;
            valid         <= 1'b0;
            err_corrected <= 1'b0;
            err_double    <= 1'b0;
            err_pos       <= 4'd0;
            corr_cnt      <= 8'd0;
            dbl_cnt       <= 8'd0;
        end else begin
            valid <= pending;
            if (pending) begin
                dataout       <= dec_data;
                err_corrected <= parity;
                err_double    <= !parity && (syndrome != 4'd0);
                err_pos       <= parity ? syndrome : 4'd0;
                if (parity && (corr_cnt != 8'hFF)) begin
                    corr_cnt <= corr_cnt + 8'd1;
                end
                if (!parity && (syndrome != 4'd0) && (dbl_cnt != 8'hFF)) begin
                    dbl_cnt <= dbl_cnt + 8'd1;
                end
            end
        end
    end

endmodule
